pcs_block_lock_fsm: RTL and testbench
=====================================

Name: pcs_block_lock_fsm

Overview:
- Receive-side block-synchronisation controller for the 64b/66b PCS, per IEEE 802.3 Clause 49 block lock.
- Monitors the 2-bit sync header of each 66-bit block presented to the descrambler.
- Commands the RX gearbox to slip one bit position until headers are consistently valid.
- Drives the word-locked/sync qualifier consumed by the descrambler (`din_synched`) and the decoder (`sync_enabled`).

Parameters:
- LOCK_CNT, 64, consecutive headers tested per window; a clean window asserts lock.
- INVLD_MAX, 16, invalid headers within one window that force loss of lock.
- SLIP_WAIT, 4, clock cycles after a slip pulse before testing resumes (gearbox realign latency); must be ≥1.
- SLIPCNT_W, 16, width of the saturating slip counter.

Ports:
- clock  in  1  PCS clock (clk156 domain).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = run; 0 = hold in LOCK_INIT.
- hdr_valid  in  1  strobe: sync_hdr belongs to a new 66-bit block this cycle.
- sync_hdr  in  2  sync header bits [65:64] of the current block.
- slip  out  1  one-cycle pulse to the RX gearbox: shift alignment by one bit.
- block_lock  out  1  registered lock status; feeds descrambler din_synched and decoder sync_enabled.
- slip_count  out  SLIPCNT_W  number of slips since reset; saturates at all-ones.

Behaviour:
- Reset (synchronous, sampled on clock rising edge): state=LOCK_INIT, slip=0, block_lock=0, slip_count=0, sh_cnt=0, invld_cnt=0, wait_cnt=0.
- Header validity: valid iff sync_hdr is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
- States:
  - LOCK_INIT: block_lock=0, counters cleared. If enable=1, go to TEST_SH next cycle.
  - TEST_SH: act only on cycles with hdr_valid=1.
    - sh_cnt increments on every tested header.
    - invld_cnt increments on every invalid header.
  - SLIP_WAIT: wait_cnt counts up to SLIP_WAIT; hdr_valid is ignored. Then clear sh_cnt/invld_cnt and return to TEST_SH.
- TEST_SH, invalid header while block_lock=0: go to SLIP immediately (one bad header breaks acquisition).
- TEST_SH, invalid header while block_lock=1 and invld_cnt reaches INVLD_MAX: go to SLIP; block_lock drops.
- SLIP action (taken in the same transition): slip=1 for exactly the next cycle, block_lock=0, slip_count += 1 (saturating). Next state is SLIP_WAIT.
- End of window (sh_cnt reaches LOCK_CNT without a slip):
  - invld_cnt==0: block_lock=1.
  - Otherwise block_lock is unchanged.
  - In both cases counters clear and testing continues in the following cycle with no gap.
- Latency:
  - block_lock rises on the cycle after the 64th clean header is sampled.
  - slip rises on the cycle after the triggering invalid header.
- Simultaneous events: if the 64th header is also the 16th invalid, SLIP takes priority over the window-end evaluation.
- Counter widths: sh_cnt is $clog2(LOCK_CNT+1) bits, invld_cnt is $clog2(INVLD_MAX+1) bits; neither wraps, both are cleared explicitly.
- enable=0 in any state: next cycle state=LOCK_INIT and block_lock=0; any in-flight slip pulse is truncated to its current cycle; slip_count is held.
- Reset asserted mid-window or mid-SLIP_WAIT: full return to reset values, with no residual slip pulse.
- hdr_valid=0 in TEST_SH: no state or counter change.

Decomposition:
- Shared package pcs_pkg:
  - state enum {LOCK_INIT, TEST_SH, SLIP_WAIT}.
  - SYNC_DATA=2'b01 and SYNC_CTRL=2'b10 constants.
  - Default LOCK_CNT/INVLD_MAX values.
- One sub-module, pcs_sat_counter (parameterised width, synchronous clear, saturating increment), instantiated for slip_count.
- The FSM and window counters stay inline.

Test Plan:
- Reset then enable=1, 64 headers of 2'b01 on consecutive hdr_valid → no slip; block_lock=1 the cycle after the 64th header; slip_count=0.
- Unlocked, 5th header 2'b11 → slip pulse of exactly 1 cycle; slip_count=1; hdr_valid ignored for 4 cycles; lock after 64 further clean headers.
- Locked, 15 invalid headers spread across one 64-header window → lock retained. Next window fully clean → block_lock stays 1.
- Locked, 16 invalid headers within one window → block_lock=0 and slip pulse the cycle after the 16th; the remaining headers of that window are not counted.
- 64th header is the 16th invalid → SLIP taken, block_lock=0, no lock assertion.
- Mid-window enable=0 for 1 cycle, then 1 → block_lock=0 next cycle, counters restart, 64 clean headers needed. Repeat with reset=1 → slip_count returns to 0. Force 65535+2 slips → slip_count holds at 65535.

Source files
------------

// File: rtl/pcs_pkg.sv
// pcs_pkg: shared types and constants for the 64b/66b receive block-lock controller.
package pcs_pkg;

    typedef enum logic [1:0] {LOCK_INIT, TEST_SH, SLIP_WAIT} state_e;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int LOCK_CNT_DEF  = 64;
    localparam int INVLD_MAX_DEF = 16;

endpackage

// File: rtl/pcs_sat_counter.sv
// pcs_sat_counter: up-counter with synchronous clear that sticks at all-ones.
module pcs_sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear)
            count <= '0;
        else if (inc && count != '1)
            count <= count + W'(1);
    end

endmodule

// File: rtl/pcs_block_lock_fsm.sv
// pcs_block_lock_fsm: 64b/66b sync-header block lock; slips the RX gearbox until
// headers are consistently valid, then qualifies the descrambler and decoder.
module pcs_block_lock_fsm #(
    parameter int LOCK_CNT  = pcs_pkg::LOCK_CNT_DEF,
    parameter int INVLD_MAX = pcs_pkg::INVLD_MAX_DEF,
    parameter int SLIP_WAIT = 4,
    parameter int SLIPCNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 hdr_valid,
    input  logic [1:0]           sync_hdr,
    output logic                 slip,
    output logic                 block_lock,
    output logic [SLIPCNT_W-1:0] slip_count
);

    import pcs_pkg::*;

    localparam int SH_W   = $clog2(LOCK_CNT + 1);
    localparam int INV_W  = $clog2(INVLD_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(LOCK_CNT);
    localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(INVLD_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    state_e             state, state_n;
    logic [SH_W-1:0]    sh_cnt, sh_n, sh_inc;
    logic [INV_W-1:0]   invld_cnt, inv_n, inv_inc;
    logic [WAIT_W-1:0]  wait_cnt, wait_n;
    logic               lock_n, slip_n, hdr_ok;

    assign hdr_ok  = (sync_hdr == SYNC_DATA) || (sync_hdr == SYNC_CTRL);
    assign sh_inc  = sh_cnt + SH_W'(1);
    assign inv_inc = invld_cnt + INV_W'(!hdr_ok);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= LOCK_INIT;
            sh_cnt     <= '0;
            invld_cnt  <= '0;
            wait_cnt   <= '0;
            block_lock <= 1'b0;
            slip       <= 1'b0;
        end else begin
            state      <= state_n;
            sh_cnt     <= sh_n;
            invld_cnt  <= inv_n;
            wait_cnt   <= wait_n;
            block_lock <= lock_n;
            slip       <= slip_n;
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh_cnt;
        inv_n   = invld_cnt;
        wait_n  = wait_cnt;
        lock_n  = block_lock;
        slip_n  = 1'b0;
        if (!enable) begin
            state_n = LOCK_INIT;
            sh_n    = '0;
            inv_n   = '0;
            wait_n  = '0;
            lock_n  = 1'b0;
        end else begin
            case (state)
                LOCK_INIT: begin
                    state_n = TEST_SH;
                    sh_n    = '0;
                    inv_n   = '0;
                    lock_n  = 1'b0;
                end
                TEST_SH: begin
                    // Slip outranks window-end evaluation when both land on one header.
                    if (hdr_valid && !hdr_ok && (!block_lock || inv_inc == INV_LAST)) begin
                        state_n = pcs_pkg::SLIP_WAIT;
                        slip_n  = 1'b1;
                        lock_n  = 1'b0;
                        sh_n    = '0;
                        inv_n   = '0;
                        wait_n  = '0;
                    end else if (hdr_valid && sh_inc == SH_LAST) begin
                        sh_n   = '0;
                        inv_n  = '0;
                        lock_n = (inv_inc == '0) ? 1'b1 : block_lock;
                    end else if (hdr_valid) begin
                        sh_n  = sh_inc;
                        inv_n = inv_inc;
                    end
                end
                pcs_pkg::SLIP_WAIT: begin
                    state_n = (wait_cnt == WAIT_LAST) ? TEST_SH : pcs_pkg::SLIP_WAIT;
                    wait_n  = (wait_cnt == WAIT_LAST) ? '0 : wait_cnt + WAIT_W'(1);
                    sh_n    = '0;
                    inv_n   = '0;
                end
                default: state_n = LOCK_INIT;
            endcase
        end
    end

    pcs_sat_counter #(.W(SLIPCNT_W)) u_slip_cnt (
        .clock (clock),
        .clear (reset),
        .inc   (!reset && slip_n),
        .count (slip_count)
    );

endmodule

// File: tb/tb_pcs_block_lock_fsm.sv
// tb_pcs_block_lock_fsm: scenario scoreboard for the block-lock controller.
module tb_pcs_block_lock_fsm;

    localparam int CW = 8;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct packed {
        logic          lock;
        logic          slp;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          hdr_valid = 1'b0;
    logic [1:0]    sync_hdr = 2'b00;
    logic          slip;
    logic          block_lock;
    logic [CW-1:0] slip_count;

    exp_t          exp_q[$];
    exp_t          obs_q[$];
    logic [CW-1:0] ec = '0;
    int            total = 0;
    int            bad = 0;

    pcs_block_lock_fsm #(.SLIPCNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .hdr_valid  (hdr_valid),
        .sync_hdr   (sync_hdr),
        .slip       (slip),
        .block_lock (block_lock),
        .slip_count (slip_count)
    );

    always #5 clock = ~clock;

    task automatic step(input logic en, input logic hv, input logic [1:0] h,
                        input logic el, input logic es);
        enable = en;
        hdr_valid = hv;
        sync_hdr = h;
        exp_q.push_back({el, es, ec});
        @(posedge clock);
        #1;
        obs_q.push_back({block_lock, slip, slip_count});
    endtask

    task automatic acquire();
        for (int i = 0; i < 64; i++)
            step(1'b1, 1'b1, (i % 2 == 1) ? 2'b10 : 2'b01, i == 63, 1'b0);
    endtask

    task automatic bump();
        ec = (ec == CMAX) ? CMAX : ec + 1'b1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        int idx = 0;
        reset = 1'b1;
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++; idx++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset #%0d got lock=%b slip=%b cnt=%0d want lock=%b slip=%b cnt=%0d",
                         idx, o.lock, o.slp, o.cnt, e.lock, e.slp, e.cnt);
            end
        end
    endtask

    task automatic test_lock_acquire();
        exp_t e, o;
        int idx = 0;
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        acquire();
        step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++; idx++;
            if (o !== e) begin
                bad++;
                $display("FAIL lock_acquire #%0d got lock=%b slip=%b cnt=%0d want lock=%b slip=%b cnt=%0d",
                         idx, o.lock, o.slp, o.cnt, e.lock, e.slp, e.cnt);
            end
        end
    endtask

    task automatic test_slip();
        exp_t e, o;
        int idx = 0;
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        bump();
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        acquire();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++; idx++;
            if (o !== e) begin
                bad++;
                $display("FAIL slip #%0d got lock=%b slip=%b cnt=%0d want lock=%b slip=%b cnt=%0d",
                         idx, o.lock, o.slp, o.cnt, e.lock, e.slp, e.cnt);
            end
        end
    endtask

    task automatic test_invalid_window();
        exp_t e, o;
        int idx = 0;
        for (int i = 0; i < 64; i++)
            step(1'b1, 1'b1, (i % 4 == 3 && i < 60) ? 2'b00 : 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 45; i++)
            step(1'b1, 1'b1, (i % 3 == 0) ? 2'b11 : 2'b01, 1'b1, 1'b0);
        bump();
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        acquire();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++; idx++;
            if (o !== e) begin
                bad++;
                $display("FAIL invalid_window #%0d got lock=%b slip=%b cnt=%0d want lock=%b slip=%b cnt=%0d",
                         idx, o.lock, o.slp, o.cnt, e.lock, e.slp, e.cnt);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e, o;
        int idx = 0;
        for (int i = 0; i < 63; i++)
            step(1'b1, 1'b1, (i >= 48) ? 2'b00 : 2'b01, 1'b1, 1'b0);
        bump();
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++; idx++;
            if (o !== e) begin
                bad++;
                $display("FAIL simultaneous #%0d got lock=%b slip=%b cnt=%0d want lock=%b slip=%b cnt=%0d",
                         idx, o.lock, o.slp, o.cnt, e.lock, e.slp, e.cnt);
            end
        end
    endtask

    task automatic test_enable();
        exp_t e, o;
        int idx = 0;
        acquire();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
        step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        acquire();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++; idx++;
            if (o !== e) begin
                bad++;
                $display("FAIL enable #%0d got lock=%b slip=%b cnt=%0d want lock=%b slip=%b cnt=%0d",
                         idx, o.lock, o.slp, o.cnt, e.lock, e.slp, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        int idx = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
        reset = 1'b1;
        ec = '0;
        step(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        bump();
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        reset = 1'b1;
        ec = '0;
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++; idx++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_mid #%0d got lock=%b slip=%b cnt=%0d want lock=%b slip=%b cnt=%0d",
                         idx, o.lock, o.slp, o.cnt, e.lock, e.slp, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t e, o;
        int idx = 0;
        for (int k = 0; k < int'(CMAX) + 2; k++) begin
            bump();
            step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
            for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        ec = '0;
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++; idx++;
            if (o !== e) begin
                bad++;
                $display("FAIL saturation #%0d got lock=%b slip=%b cnt=%0d want lock=%b slip=%b cnt=%0d",
                         idx, o.lock, o.slp, o.cnt, e.lock, e.slp, e.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_slip();
        test_invalid_window();
        test_simultaneous();
        test_enable();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
